bcd_scan_driver: RTL and testbench
==================================

# bcd_scan_driver

Parametrised successor to the fixed 8-digit balance display driver. It accepts a `WIDTH`-bit unsigned binary value on a load strobe and converts it to `DIGITS` BCD digits with a sequential double-dabble engine. It continuously scans the committed digits, most-significant digit first, to the external counter/decoder chain over `cclr_neg`/`num`/`clk_out`. Over the old driver it adds:
- overflow saturation;
- optional leading-zero blanking;
- a busy handshake;
- tear-free frame updates.

## Interface
- `WIDTH`, 32: binary input width, 1..64.
- `DIGITS`, 8: displayed decimal digits, 1..16.
- `DIV`, 4: `clk` cycles per `clk_out` half-period, ≥1.
- `BLANK_LZ`, 1: 1 = leading zeros are shown as blank code 4'hF.
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `value`, in, `WIDTH`: binary value, sampled on an accepted `load`.
- `load`, in, 1: conversion request, one-cycle strobe.
- `busy`, out, 1: conversion in progress; `load` is ignored while high.
- `ovf`, out, 1: the last committed value was ≥ 10^`DIGITS`.
- `cclr_neg`, out, 1: active-low clear to the external digit counter.
- `num`, out, 4: current digit code (0-9, or F = blank).
- `clk_out`, out, 1: registered scan clock; the external device samples on its rising edge.
- `frame_done`, out, 1: one-`clk` pulse at the end of each scan frame.

## Operation
- **Reset values:** `busy`=0, `ovf`=0, `cclr_neg`=0, `num`=0, `clk_out`=0, `frame_done`=0.
  - Divider counter = 0; slot = 0.
  - Pending and display buffers hold value 0, with the blanking rule applied.
- **Conversion FSM, IDLE → CONV → COMMIT → IDLE:**
  - IDLE: `load`=1 latches `value` into the shift register, clears the BCD register and the overflow flag, and enters CONV.
  - CONV: `WIDTH` iterations, one per cycle. In each iteration every BCD nibble ≥5 gets +3, then {BCD, bin} shifts left by 1. A 1 shifted out of the top nibble sets the sticky overflow flag.
  - COMMIT: writes the pending buffer and `ovf` in one cycle, then returns to IDLE.
- **Overflow:** the pending buffer is forced to all 9s (no blanking) and `ovf`=1. A later in-range conversion clears `ovf` at its COMMIT.
- **Blanking** (`BLANK_LZ`=1): every leading zero digit becomes F, applied at COMMIT. The least-significant digit is never blanked, so value 0 displays as F…F,0.
- **Load handling:**
  - `load` while `busy` is dropped; there is no queue.
  - `rst` together with `load`: reset wins.
- **Scan:**
  - The divider counts 0..`DIV`-1; `clk_out` toggles on each wrap.
  - On every 1→0 toggle the slot advances modulo `DIGITS`+1.
  - Slot 0: `cclr_neg`=0, `num`=0. Slots 1..`DIGITS`: `cclr_neg`=1, `num` = display digit, MS first.
  - At entry to slot 0 the display buffer is copied from the pending buffer. A frame therefore never mixes two values.
- **Arithmetic:** pure shifts and 4-bit adds; no multipliers or dividers.

## Timing
- `load` is accepted in cycle t.
  - `busy`=1 from t+1 through t+`WIDTH`+1; COMMIT occurs at cycle t+`WIDTH`+1.
  - `busy`=0 and the pending buffer/`ovf` are valid at t+`WIDTH`+2.
  - The earliest next accepted `load` is at t+`WIDTH`+2.
- **`clk_out`:** period 2·`DIV` `clk` cycles; the first rising edge is at cycle `DIV` after reset release.
- **`num`/`cclr_neg`:** change only in the cycle `clk_out` goes 1→0, so they are stable for `DIV` cycles before and after each rising edge.
- **Frame:** (`DIGITS`+1)·2·`DIV` cycles.
- **`frame_done`:** asserted in the cycle the last digit slot ends, coincident with the wrap to slot 0.
- **Display latency:** a committed value appears at the next slot-0 entry, at most one frame plus one cycle after COMMIT.
- **Reset mid-operation:** the conversion is aborted with no commit, and the scan restarts at slot 0 with `cclr_neg`=0 on the next cycle.

## Test plan
- **Basic conversion.** WIDTH=32, DIGITS=8, DIV=2. Load 12345678 → `busy` high for exactly 33 cycles, `ovf`=0; the next full frame shows a clear slot, then `num` = 1,2,3,4,5,6,7,8 on successive `clk_out` rising edges.
- **Blanking.** With BLANK_LZ=1, load 42 → F,F,F,F,F,F,4,2; load 0 → F×7,0. With BLANK_LZ=0, load 42 → 0,0,0,0,0,0,4,2.
- **Overflow and recovery.** Load 100000000 → `ovf`=1, all digits 9. Then load 5 → `ovf`=0, display F×7,5. Also at DIGITS=4, WIDTH=16: load 65535 → `ovf`=1, 9,9,9,9; load 9999 → `ovf`=0.
- **Dropped load and tear-free update.** Pulse `load` with 7 while `busy` → dropped; the first value still commits. A COMMIT landing mid-frame → the current frame is unchanged and the new digits start at the next slot 0.
- **Reset mid-operation.** Assert `rst` during CONV and during slot 5 → the next cycle shows all outputs at reset values, `ovf` and the display are unaffected by the aborted value, and `cclr_neg` stays low for the whole first slot.
- **Divider sweep.** DIV=1 and DIV=7 → `clk_out` period of 2 and 14 cycles; `frame_done` period = (`DIGITS`+1)·2·`DIV` cycles, one cycle wide.

Source files
------------

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: binary-to-BCD converter driving a multiplexed digit counter/decoder chain
// Ports: clk/rst (sync, active-high); value/load in, busy handshake out; ovf = last committed value >= 10^DIGITS;
// cclr_neg/num/clk_out drive the external chain, MS digit first; frame_done pulses once per scan frame.
module bcd_scan_driver #(
  parameter int WIDTH = 32,
  parameter int DIGITS = 8,
  parameter int DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic             cclr_neg,
  output logic [3:0]       num,
  output logic             clk_out,
  output logic             frame_done
);
  localparam int bw = 4 * DIGITS;
  localparam int cw = $clog2(WIDTH + 1);
  localparam int dw = DIV > 1 ? $clog2(DIV) : 1;
  localparam int sw = $clog2(DIGITS + 1);
  localparam logic [bw-1:0] rst_disp = BLANK_LZ ? {bw{1'b1}} << 4 : '0;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] bin;
  logic [bw-1:0] bcd, adj, fmt, pend, disp;
  logic [cw-1:0] cnt;
  logic [dw-1:0] dcnt;
  logic [sw-1:0] slot, slot_nx;
  logic [3:0] dig;
  logic ovf_acc, lead, wrap, fall;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (load ? CONV : IDLE) :
               state == CONV ? (cnt == cw'(WIDTH - 1) ? COMMIT : CONV) : IDLE;
  end
  assign busy = state != IDLE;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Leading-zero blanking walks down from the MS digit; digit 0 is always shown.
  always_comb begin
    fmt = bcd;
    lead = BLANK_LZ;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && bcd[4*i +: 4] == 4'd0;
      fmt[4*i +: 4] = lead ? 4'hF : bcd[4*i +: 4];
    end
    fmt = ovf_acc ? {DIGITS{4'h9}} : fmt;
  end
  // A 1 leaving the top nibble means the value needs more than DIGITS digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      pend <= rst_disp;
      ovf <= 1'b0;
    end else if (state == IDLE && load) begin
      bin <= value;
      bcd <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
    end else if (state == CONV) begin
      {bcd, bin} <= {adj[bw-2:0], bin, 1'b0};
      ovf_acc <= ovf_acc | adj[bw-1];
      cnt <= cnt + 1'b1;
    end else if (state == COMMIT) begin
      pend <= fmt;
      ovf <= ovf_acc;
    end
  end
  assign wrap = dcnt == dw'(DIV - 1);
  assign fall = wrap && clk_out;
  always_comb begin
    slot_nx = fall ? (slot == sw'(DIGITS) ? '0 : slot + 1'b1) : slot;
    dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) dig = slot_nx == sw'(DIGITS - i) ? disp[4*i +: 4] : dig;
  end
  // Outputs only move on the clk_out falling edge; frame_done lands in the first cycle of slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      clk_out <= 1'b0;
      slot <= '0;
      cclr_neg <= 1'b0;
      num <= 4'd0;
      frame_done <= 1'b0;
      disp <= rst_disp;
    end else begin
      dcnt <= wrap ? '0 : dcnt + 1'b1;
      clk_out <= clk_out ^ wrap;
      slot <= slot_nx;
      frame_done <= fall && slot == sw'(DIGITS);
      if (fall) begin
        cclr_neg <= slot_nx != '0;
        num <= dig;
        if (slot_nx == '0) disp <= pend;
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: directed self-checking bench for bcd_scan_driver across three parameter sets
module tb_bcd_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] val [3];
  logic ld [3];
  logic bz [3];
  logic ov [3];
  logic cc [3];
  logic co [3];
  logic fd [3];
  logic [3:0] nm [3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_scan_driver #(.WIDTH(32), .DIGITS(8), .DIV(2), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .rst(rst), .value(val[0]), .load(ld[0]), .busy(bz[0]), .ovf(ov[0]),
    .cclr_neg(cc[0]), .num(nm[0]), .clk_out(co[0]), .frame_done(fd[0]));
  bcd_scan_driver #(.WIDTH(16), .DIGITS(4), .DIV(1), .BLANK_LZ(1'b0)) u1 (
    .clk(clk), .rst(rst), .value(val[1][15:0]), .load(ld[1]), .busy(bz[1]), .ovf(ov[1]),
    .cclr_neg(cc[1]), .num(nm[1]), .clk_out(co[1]), .frame_done(fd[1]));
  bcd_scan_driver #(.WIDTH(8), .DIGITS(2), .DIV(7), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .rst(rst), .value(val[2][7:0]), .load(ld[2]), .busy(bz[2]), .ovf(ov[2]),
    .cclr_neg(cc[2]), .num(nm[2]), .clk_out(co[2]), .frame_done(fd[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rise(input int k);
    int n = 0;
    while (co[k] && n < 100) begin @(negedge clk); n++; end
    while (!co[k] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rise_timeout", n, 0);
  endtask

  task automatic wait_fd(input int k, input string tag);
    int n = 0;
    while (!fd[k] && n < 400) begin @(negedge clk); n++; end
    chk(tag, n < 400, 1);
  endtask

  task automatic get_frame(input int k, input int nd, output logic [31:0] f);
    f = '0;
    @(negedge clk);
    wait_fd(k, "frame_start");
    chk("frame_done_clr", cc[k], 0);
    rise(k);
    chk("clear_slot_cclr", cc[k], 0);
    chk("clear_slot_num", nm[k], 0);
    for (int d = 0; d < nd; d++) begin
      rise(k);
      chk("digit_cclr", cc[k], 1);
      f = {f[27:0], nm[k]};
    end
  endtask

  task automatic do_load(input int k, input logic [31:0] v, output int n);
    @(negedge clk);
    val[k] = v;
    ld[k] = 1'b1;
    @(negedge clk);
    ld[k] = 1'b0;
    n = 0;
    while (bz[k] && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic conv(input int k, input logic [31:0] v, input int bl, input logic ovf_exp,
                      input int nd, input logic [31:0] fexp, input string tag);
    int n;
    logic [31:0] f;
    do_load(k, v, n);
    chk({tag, "_busy"}, n, bl);
    chk({tag, "_ovf"}, ov[k], ovf_exp);
    get_frame(k, nd, f);
    chk({tag, "_frame"}, f, fexp);
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", bz[0], 0);
    chk("rst_ovf", ov[0], 0);
    chk("rst_cclr", cc[0], 0);
    chk("rst_num", nm[0], 0);
    chk("rst_clk_out", co[0], 0);
    chk("rst_frame_done", fd[0], 0);
    chk("rst_cclr_u1", cc[1], 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rel_clk_out", co[0], i == 2 || i == 3);
      chk("rel_cclr", cc[0], i == 4);
      @(negedge clk);
    end
  endtask

  task automatic per(input int k, input int exp_co, input int exp_fd, input string tag);
    int c;
    rise(k);
    c = cyc;
    rise(k);
    chk({tag, "_clk_out_period"}, cyc - c, exp_co);
    wait_fd(k, {tag, "_fd_first"});
    c = cyc;
    @(negedge clk);
    chk({tag, "_fd_width"}, fd[k], 0);
    wait_fd(k, {tag, "_fd_second"});
    chk({tag, "_fd_period"}, cyc - c, exp_fd);
  endtask

  initial begin
    int n;
    logic [31:0] f;
    for (int k = 0; k < 3; k++) begin
      val[k] = '0;
      ld[k] = 1'b0;
    end
    reset_seq();
    get_frame(0, 8, f);
    chk("reset_frame_u0", f, 32'hFFFFFFF0);
    get_frame(1, 4, f);
    chk("reset_frame_u1", f, 32'h0000);
    conv(0, 12345678, 33, 1'b0, 8, 32'h12345678, "basic");
    conv(0, 42, 33, 1'b0, 8, 32'hFFFFFF42, "blank42");
    conv(0, 0, 33, 1'b0, 8, 32'hFFFFFFF0, "blank0");
    conv(1, 42, 17, 1'b0, 4, 32'h0042, "noblank42");
    conv(0, 100000000, 33, 1'b1, 8, 32'h99999999, "ovf8");
    conv(0, 5, 33, 1'b0, 8, 32'hFFFFFFF5, "recover8");
    conv(1, 65535, 17, 1'b1, 4, 32'h9999, "ovf4");
    conv(1, 9999, 17, 1'b0, 4, 32'h9999, "max4");
    conv(2, 255, 9, 1'b1, 2, 32'h99, "ovf2");
    conv(2, 7, 9, 1'b0, 2, 32'hF7, "blank2");
    @(negedge clk);
    val[0] = 12345678;
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    n = 0;
    while (bz[0] && n < 100) begin
      ld[0] = n == 5;
      if (n == 5) val[0] = 7;
      n++;
      @(negedge clk);
    end
    ld[0] = 1'b0;
    chk("drop_busy_len", n, 33);
    @(negedge clk);
    chk("drop_idle", bz[0], 0);
    get_frame(0, 8, f);
    chk("drop_frame", f, 32'h12345678);
    wait_fd(0, "tear_sync");
    repeat (6) @(negedge clk);
    val[0] = 87654321;
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    get_frame(0, 8, f);
    chk("tear_old_frame", f, 32'h12345678);
    chk("tear_busy_done", bz[0], 0);
    get_frame(0, 8, f);
    chk("tear_new_frame", f, 32'h87654321);
    chk("tear_ovf", ov[0], 0);
    @(negedge clk);
    val[0] = 999999999;
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("conv_busy", bz[0], 1);
    reset_seq();
    repeat (40) @(negedge clk);
    chk("abort_busy", bz[0], 0);
    chk("abort_ovf", ov[0], 0);
    get_frame(0, 8, f);
    chk("abort_frame", f, 32'hFFFFFFF0);
    conv(0, 12345678, 33, 1'b0, 8, 32'h12345678, "pre_slot5");
    wait_fd(0, "slot5_sync");
    repeat (21) @(negedge clk);
    chk("slot5_cclr", cc[0], 1);
    chk("slot5_num", nm[0], 5);
    reset_seq();
    get_frame(0, 8, f);
    chk("slot5_reset_frame", f, 32'hFFFFFFF0);
    per(1, 2, 10, "div1");
    per(2, 14, 42, "div7");
    per(0, 4, 36, "div2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
